// File: rtl/coarse_meas_ctrl.sv
// Start/stop sequencer for the TDC coarse counter; merges coarse and fine codes into one valid/ready result.
// Define COARSE_MEAS_DROP_CNT_EN to add drop_cnt, a saturating count of start hits ignored while busy.
module coarse_meas_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int FINE_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_hit,
  input  logic                  stop_hit,
  input  logic [FINE_WIDTH-1:0] fine_start_in,
  input  logic [FINE_WIDTH-1:0] fine_stop_in,
  input  logic [DATA_WIDTH-1:0] coarse_time,
  output logic                  cnt_clr,
  output logic                  cnt_latch,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_coarse,
  output logic [FINE_WIDTH-1:0] m_fine_start,
  output logic [FINE_WIDTH-1:0] m_fine_stop,
  output logic                  m_timeout,
  output logic                  busy
`ifdef COARSE_MEAS_DROP_CNT_EN
  ,output logic [15:0]          drop_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, ARMED, LATCH, WAIT, OUT} state_t;

  localparam logic [DATA_WIDTH-1:0] TIMEOUT_V = DATA_WIDTH'(TIMEOUT_CYC);
  localparam logic [DATA_WIDTH-1:0] ONE       = DATA_WIDTH'(1);

  state_t                  state_q;
  logic [DATA_WIDTH-1:0]   wd_q;
  logic                    clr_q;
  logic                    latch_q;
  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   coarse_q;
  logic [FINE_WIDTH-1:0]   fine_start_q;
  logic [FINE_WIDTH-1:0]   fine_stop_q;
  logic                    timeout_q;
  logic                    busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wd_q         <= '0;
      clr_q        <= 1'b0;
      latch_q      <= 1'b0;
      valid_q      <= 1'b0;
      coarse_q     <= '0;
      fine_start_q <= '0;
      fine_stop_q  <= '0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      clr_q   <= 1'b0;
      latch_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_hit) begin
            state_q      <= ARMED;
            clr_q        <= 1'b1;
            fine_start_q <= fine_start_in;
            wd_q         <= ONE;
            busy_q       <= 1'b1;
          end
        end
        ARMED: begin
          // A stop arriving on the watchdog's final cycle still yields a real measurement.
          if (stop_hit) begin
            state_q     <= LATCH;
            latch_q     <= 1'b1;
            fine_stop_q <= fine_stop_in;
          end else if (wd_q == TIMEOUT_V) begin
            state_q     <= OUT;
            valid_q     <= 1'b1;
            timeout_q   <= 1'b1;
            coarse_q    <= TIMEOUT_V;
            fine_stop_q <= '0;
          end else begin
            wd_q <= wd_q + ONE;
          end
        end
        LATCH: state_q <= WAIT;
        WAIT: begin
          // The counter clears one cycle after start, so it reads one short.
          coarse_q  <= coarse_time + ONE;
          valid_q   <= 1'b1;
          timeout_q <= 1'b0;
          state_q   <= OUT;
        end
        OUT: begin
          if (m_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cnt_clr      = clr_q;
  assign cnt_latch    = latch_q;
  assign m_valid      = valid_q;
  assign m_coarse     = coarse_q;
  assign m_fine_start = fine_start_q;
  assign m_fine_stop  = fine_stop_q;
  assign m_timeout    = timeout_q;
  assign busy         = busy_q;

`ifdef COARSE_MEAS_DROP_CNT_EN
  logic [15:0] drop_q;
  logic [15:0] drop_d;

  always_comb begin
    drop_d = drop_q;
    if (start_hit && (state_q != IDLE) && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_coarse_meas_ctrl.sv
// Randomized bench for coarse_meas_ctrl with an attached coarse counter and an arithmetic result model.
module tb_coarse_meas_ctrl;

  localparam int T = 20;

  logic        clk;
  logic        rst_n;
  logic        start_hit;
  logic        stop_hit;
  logic [7:0]  fine_start_in;
  logic [7:0]  fine_stop_in;
  logic [31:0] coarse_time;
  logic        cnt_clr;
  logic        cnt_latch;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_coarse;
  logic [7:0]  m_fine_start;
  logic [7:0]  m_fine_stop;
  logic        m_timeout;
  logic        busy;
`ifdef COARSE_MEAS_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_drop = 0;

  coarse_meas_ctrl #(
    .DATA_WIDTH (32),
    .FINE_WIDTH (8),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_hit    (start_hit),
    .stop_hit     (stop_hit),
    .fine_start_in(fine_start_in),
    .fine_stop_in (fine_stop_in),
    .coarse_time  (coarse_time),
    .cnt_clr      (cnt_clr),
    .cnt_latch    (cnt_latch),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_coarse     (m_coarse),
    .m_fine_start (m_fine_start),
    .m_fine_stop  (m_fine_stop),
    .m_timeout    (m_timeout),
    .busy         (busy)
`ifdef COARSE_MEAS_DROP_CNT_EN
    ,.drop_cnt    (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running coarse counter: clear on cnt_clr, snapshot on cnt_latch.
  logic [31:0] ctr;
  always_ff @(posedge clk) begin
    if (cnt_latch) coarse_time <= ctr;
    ctr <= cnt_clr ? 32'd0 : ctr + 32'd1;
  end

  task automatic bump_drop();
    if (exp_drop < 65535) exp_drop = exp_drop + 1;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ((|{cnt_clr, cnt_latch, m_valid, m_coarse, m_fine_start, m_fine_stop, m_timeout, busy}) !== 1'b0) begin
      errors++;
      $display("FAIL %s: outputs clr=%b latch=%b vld=%b coarse=%0d fs=%h fp=%h to=%b busy=%b, required all 0",
               name, cnt_clr, cnt_latch, m_valid, m_coarse, m_fine_start, m_fine_stop, m_timeout, busy);
    end
`ifdef COARSE_MEAS_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL %s_drop: drop_cnt=%0d required 0", name, drop_cnt);
    end
`endif
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start_hit = 1'b0;
      stop_hit  = 1'($urandom_range(0, 1));
      m_ready   = 1'($urandom_range(0, 1));
      @(negedge clk);
      stop_hit = 1'b0;
      checks++;
      if ({cnt_clr, cnt_latch, m_valid, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL idle: clr/latch/vld/busy=%b required 0000", {cnt_clr, cnt_latch, m_valid, busy});
      end
    end
  endtask

  // One measurement: start at edge 0, stop at edge d (d > T means no stop, so the watchdog fires).
  // rd = cycles of backpressure after valid rises; extra = random ignored hits; s0 = stop with start;
  // sah = start on the handshake edge.
  task automatic do_meas(input int d, input logic [7:0] fs, input logic [7:0] ff, input int rd,
                         input bit extra, input bit s0, input bit sah);
    bit          normal;
    int          stop_end, v, h, n;
    logic [31:0] e_coarse;
    logic [7:0]  e_fp;
    logic [3:0]  e_ctl;
    normal   = (d <= T);
    stop_end = normal ? d : T;
    v        = normal ? d + 2 : T;
    h        = v + rd + 1;
    e_coarse = normal ? 32'(d) : 32'(T);
    e_fp     = normal ? ff : 8'h00;
    start_hit     = 1'b1;
    fine_start_in = fs;
    stop_hit      = s0;
    fine_stop_in  = 8'($urandom);
    m_ready       = 1'($urandom_range(0, 1));
    for (int r = 0; r <= h; r++) begin
      @(negedge clk);
      start_hit = 1'b0;
      stop_hit  = 1'b0;
      e_ctl = {r == 0, normal && (r == d), (r >= v) && (r < h), r < h};
      checks++;
      if ({cnt_clr, cnt_latch, m_valid, busy} !== e_ctl) begin
        errors++;
        $display("FAIL ctl d=%0d r=%0d: clr/latch/vld/busy=%b required %b",
                 d, r, {cnt_clr, cnt_latch, m_valid, busy}, e_ctl);
      end
      if ((r >= v) && (r < h)) begin
        checks++;
        if ({m_coarse, m_fine_start, m_fine_stop, m_timeout} !== {e_coarse, fs, e_fp, !normal}) begin
          errors++;
          $display("FAIL result d=%0d r=%0d: coarse=%0d fs=%h fp=%h to=%b required coarse=%0d fs=%h fp=%h to=%b",
                   d, r, m_coarse, m_fine_start, m_fine_stop, m_timeout, e_coarse, fs, e_fp, !normal);
        end
      end
`ifdef COARSE_MEAS_DROP_CNT_EN
      checks++;
      if (drop_cnt !== 16'(exp_drop)) begin
        errors++;
        $display("FAIL drop d=%0d r=%0d: drop_cnt=%0d required %0d", d, r, drop_cnt, exp_drop);
      end
`endif
      if (r < h) begin
        n = r + 1;
        stop_hit  = (normal && (n == d)) || (extra && (n > stop_end) && ($urandom_range(0, 2) == 0));
        start_hit = (sah && (n == h)) || (extra && ($urandom_range(0, 2) == 0));
        if (start_hit) bump_drop();
        fine_start_in = 8'($urandom);
        fine_stop_in  = (n == d) ? ff : 8'($urandom);
        m_ready       = (n <= v) ? 1'($urandom_range(0, 1)) : (n == h);
      end
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_hit = 1'b0; stop_hit = 1'b0; m_ready = 1'b0;
    fine_start_in = 8'h00; fine_stop_in = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    exp_drop = 0;
    idle_cycles(4);
  endtask

  task automatic test_basic();
    idle_cycles(5);
    do_meas(7, 8'hA5, 8'h3C, 0, 0, 0, 0);
    do_meas(12, 8'h01, 8'hFE, 1, 0, 0, 0);
  endtask

  task automatic test_min_distance();
    do_meas(1, 8'h5A, 8'hC3, 0, 0, 0, 0);
    do_meas(1, 8'h77, 8'h88, 0, 0, 1, 0);
    do_meas(5, 8'h12, 8'h34, 0, 0, 1, 0);
  endtask

  task automatic test_timeout();
    do_meas(T + 1, 8'hE1, 8'h99, 0, 0, 0, 0);
    do_meas(T, 8'h42, 8'h24, 0, 0, 0, 0);
    do_meas(T - 1, 8'h10, 8'h20, 0, 0, 0, 0);
    do_meas(T + 3, 8'h66, 8'h55, 3, 1, 1, 0);
  endtask

  task automatic test_backpressure();
    do_meas(6, 8'hAB, 8'hCD, 5, 1, 0, 1);
    do_meas(T + 1, 8'h3E, 8'h7F, 5, 1, 0, 1);
  endtask

  task automatic test_reset_mid();
    // Reset while armed: no result and no late watchdog result afterwards.
    start_hit = 1'b1; fine_start_in = 8'h11; m_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      start_hit = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("reset_armed");
    rst_n = 1'b1;
    exp_drop = 0;
    idle_cycles(T + 4);
    do_meas(3, 8'h21, 8'h43, 0, 0, 0, 0);
    // Reset while holding a result in OUT.
    start_hit = 1'b1; fine_start_in = 8'h99; m_ready = 1'b0;
    for (int r = 0; r <= 5; r++) begin
      @(negedge clk);
      start_hit = 1'b0;
      stop_hit  = (r + 1 == 3);
      fine_stop_in = 8'h5C;
    end
    stop_hit = 1'b0;
    checks++;
    if ({m_valid, m_coarse} !== {1'b1, 32'd3}) begin
      errors++;
      $display("FAIL pre_reset_out: vld=%b coarse=%0d required vld=1 coarse=3", m_valid, m_coarse);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("reset_out");
    rst_n = 1'b1;
    exp_drop = 0;
    idle_cycles(3);
    do_meas(9, 8'h6D, 8'hD6, 2, 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    do_meas(4, 8'h0F, 8'hF0, 0, 0, 0, 1);
    do_meas(9, 8'h1E, 8'hE1, 0, 0, 0, 1);
    do_meas(2, 8'h2D, 8'hD2, 2, 0, 0, 0);
    do_meas(T + 2, 8'h3C, 8'hC3, 0, 0, 0, 1);
    do_meas(1, 8'h4B, 8'hB4, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      do_meas($urandom_range(1, T + 4), 8'($urandom), 8'($urandom), $urandom_range(0, 4),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle_cycles($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_distance();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coarse_meas_ctrl.md
Name: coarse_meas_ctrl

Overview:
- Measurement sequencer that drives the TDC coarse counter and reads it back.
- Converts start/stop hit pulses into single-cycle counter clear and latch strobes, then reads the latched coarse time one cycle later.
- Merges the coarse time with the fine codes and presents one result word on a valid/ready stream for the readout path.
- Includes a watchdog timeout for a stop hit that never arrives.

Parameters:
- DATA_WIDTH, 32, coarse counter / result coarse width; must match the coarse counter instance.
- FINE_WIDTH, 8, width of each fine (delay-line) code.
- TIMEOUT_CYC, 1000000, maximum start-to-stop distance in clk cycles. Must be < 2^DATA_WIDTH and >= 2.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous reset, active-low.
- start_hit  in  1  one-cycle start event pulse, synchronous to clk.
- stop_hit  in  1  one-cycle stop event pulse, synchronous to clk.
- fine_start_in  in  FINE_WIDTH  fine code, valid in the start_hit cycle.
- fine_stop_in  in  FINE_WIDTH  fine code, valid in the stop_hit cycle.
- coarse_time  in  DATA_WIDTH  latched value from the coarse counter.
- cnt_clr  out  1  registered clear strobe to the coarse counter.
- cnt_latch  out  1  registered latch strobe to the coarse counter.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accept.
- m_coarse  out  DATA_WIDTH  start-to-stop distance in clk cycles.
- m_fine_start  out  FINE_WIDTH  captured start fine code.
- m_fine_stop  out  FINE_WIDTH  captured stop fine code; 0 on timeout.
- m_timeout  out  1  result produced by the watchdog.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0 at a posedge):
  - state to IDLE.
  - All outputs 0: cnt_clr, cnt_latch, m_valid, m_coarse, m_fine_*, m_timeout, busy.
  - Watchdog counter wd to 0.
  - Reset mid-measurement aborts it; no result is emitted.
- States: IDLE, ARMED, LATCH, WAIT, OUT.
- IDLE:
  - start_hit at edge E0 -> ARMED.
  - cnt_clr=1 for exactly one cycle (E0..E1), capture fine_start_in, wd<=1.
  - stop_hit is ignored in IDLE.
- ARMED:
  - Each edge without stop: wd<=wd+1.
  - stop_hit at edge Es (Es>E0) -> LATCH. cnt_latch=1 for one cycle, capture fine_stop_in, D<=wd, so D=Es-E0.
  - start_hit in ARMED is ignored; the first start wins.
  - If wd==TIMEOUT_CYC and stop_hit=0 -> OUT with m_valid=1, m_timeout=1, m_coarse=TIMEOUT_CYC, m_fine_stop=0.
  - stop_hit on the same edge as wd==TIMEOUT_CYC: the stop wins.
- LATCH: the counter samples cnt_latch at edge Es+1 -> WAIT.
- WAIT:
  - At edge Es+2: m_coarse <= coarse_time + 1, truncated to DATA_WIDTH, modulo 2^DATA_WIDTH.
  - The counter reads D-1, because it clears one cycle after start.
  - m_valid<=1, m_timeout<=0 -> OUT.
- OUT:
  - m_valid and all m_* held stable until m_valid&&m_ready.
  - On handshake: m_valid<=0 -> IDLE.
  - start_hit/stop_hit during OUT, including the handshake edge, are ignored (dropped).
- Latency: stop_hit edge Es -> m_valid high after edge Es+2. Back-to-back: next start is accepted the cycle after the handshake.
- Strobe rules:
  - cnt_clr and cnt_latch are never high in the same cycle.
  - Each is a single-cycle pulse per measurement.
  - Neither is asserted in OUT.

Optional Feature:
- Macro: COARSE_MEAS_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt [15:0], reset 0.
  - Increments once per start_hit ignored in ARMED, LATCH, WAIT or OUT.
  - Saturates at 16'hFFFF.
- Undefined: port and logic absent; the ignored hits are simply discarded.

Test Plan:
- Basic: start at cycle 10, stop at cycle 17, counter model attached, m_ready=1 -> cnt_clr at 10-11, cnt_latch at 17-18, m_valid at cycle 19, m_coarse=7, fine codes as driven, m_timeout=0.
- Minimum distance: stop one cycle after start -> m_coarse=1; stop in the same cycle as start -> stop ignored, stays ARMED.
- Timeout with TIMEOUT_CYC=20: start only -> m_valid 20 cycles after start, m_timeout=1, m_coarse=20, m_fine_stop=0. Stop exactly at wd==20 -> normal result, m_coarse=20, m_timeout=0.
- Backpressure: m_ready=0 for 5 cycles in OUT with extra start/stop pulses -> outputs held stable, one result only; with the macro defined, drop_cnt counts the ignored starts.
- Reset: rst_n=0 in ARMED and in OUT -> next cycle all outputs 0, IDLE, no result; a fresh measurement then works.
- Back-to-back: handshake edge coincides with start_hit -> start ignored; start one cycle later -> accepted, m_coarse correct.
